// File: rtl/uart_csr_bank_pkg.sv
// ----------------------------------------------------------------------------
// uart_csr_bank_pkg
//   Shared types and constants for the multi-channel 16550-style CSR bank.
//   Holds register layouts (LCR, FCR, LSR, divisor, IER, IIR), the register
//   offset map and the IIR interrupt identification codes.
//   Optional feature macro used by the bank: UART_CSR_IRQ_EN.
// ----------------------------------------------------------------------------
package uart_csr_bank_pkg;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick_par;
    logic       even_par;
    logic       par_en;
    logic       stop2;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic [1:0] rx_trig;
    logic [1:0] rsvd;
    logic       dma_mode;
    logic       tx_rst;
    logic       rx_rst;
    logic       fifo_en;
  } fcr_t;

  typedef struct packed {
    logic fifo_err;
    logic temt;
    logic thre;
    logic bi;
    logic fe;
    logic pe;
    logic oe;
    logic dr;
  } lsr_t;

  typedef struct packed {
    logic [7:0] dlm;
    logic [7:0] dll;
  } div_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       edssi;
    logic       elsi;
    logic       etbei;
    logic       erbfi;
  } ier_t;

  typedef struct packed {
    logic [1:0] fifo_en;
    logic [1:0] rsvd;
    logic [3:0] id;
  } iir_t;

  // Register offsets (DLL/DLM alias RBR/IER when LCR.dlab=1)
  localparam logic [2:0] UART_OFS_RBR = 3'd0;
  localparam logic [2:0] UART_OFS_IER = 3'd1;
  localparam logic [2:0] UART_OFS_IIR = 3'd2;
  localparam logic [2:0] UART_OFS_LCR = 3'd3;
  localparam logic [2:0] UART_OFS_MCR = 3'd4;
  localparam logic [2:0] UART_OFS_LSR = 3'd5;
  localparam logic [2:0] UART_OFS_MSR = 3'd6;
  localparam logic [2:0] UART_OFS_SCR = 3'd7;

  // IIR[3:0] identification codes, highest priority first
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTO  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  localparam lcr_t LCR_RESET = 8'h03;

  // FCR bits 2:1 are self-clearing reset commands, so they are never stored.
  function automatic fcr_t fcr_store(input logic [7:0] w);
    return {w[7:6], 2'b00, w[3], 2'b00, w[0]};
  endfunction

endpackage

// File: rtl/uart_csr_chan.sv
// ----------------------------------------------------------------------------
// uart_csr_chan
//   One channel of the CSR bank: LCR/FCR/SCR/IER/divisor storage, sticky LSR
//   error bits with clear-on-read, and the prioritised IIR / irq logic.
//   Optional feature macro: UART_CSR_IRQ_EN (IER writable, IIR priority, irq).
// Ports
//   clk, rst                 clock, async active-high reset
//   wr_i, rd_i               channel-qualified write/read strobes
//   addr_i, wdata_i          register offset, write data
//   rx_data_i                RX FIFO head byte
//   rx_nonempty_i .. temt_i  live LSR sources
//   oe_i, pe_i, fe_i, bi_i   error event pulses
//   rx_trig_hit_i, rx_timeout_i  RX interrupt sources
//   rd_data_o                combinational read value (registered by the top)
//   rx_pop_o, tx_push_o      registered access pulses
//   lcr_o, div_o, fcr_o      stored configuration
//   rx_rst_p_o, tx_rst_p_o   FIFO reset pulses
//   irq_o                    registered interrupt request
// ----------------------------------------------------------------------------
module uart_csr_chan
  import uart_csr_bank_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_nonempty_i,
  input  logic       rx_fifo_err_i,
  input  logic       thre_i,
  input  logic       temt_i,
  input  logic       oe_i,
  input  logic       pe_i,
  input  logic       fe_i,
  input  logic       bi_i,
  input  logic       rx_trig_hit_i,
  input  logic       rx_timeout_i,
  output logic [7:0] rd_data_o,
  output logic       rx_pop_o,
  output logic       tx_push_o,
  output lcr_t       lcr_o,
  output div_t       div_o,
  output fcr_t       fcr_o,
  output logic       rx_rst_p_o,
  output logic       tx_rst_p_o,
  output logic       irq_o
);

  lcr_t       lcr_q, lcr_d;
  div_t       div_q, div_d;
  fcr_t       fcr_q, fcr_d;
  ier_t       ier_q, ier_d;
  logic [7:0] scr_q, scr_d;
  logic [3:0] sticky_q, sticky_d;   // {bi, fe, pe, oe}
  logic       rx_pop_q, rx_pop_d;
  logic       tx_push_q, tx_push_d;
  logic       rx_rst_q, rx_rst_d;
  logic       tx_rst_q, tx_rst_d;
  logic       irq_q, irq_d;
  logic       thre_pend_q, thre_pend_d;
  iir_t       iir;
  lsr_t       lsr;

  assign lsr = {rx_fifo_err_i, temt_i, thre_i, sticky_q, rx_nonempty_i};

  always_comb begin
    iir         = '0;
    iir.fifo_en = {2{fcr_q.fifo_en}};
    iir.id      = IIR_NONE;
`ifdef UART_CSR_IRQ_EN
    if (ier_q.elsi && (|sticky_q))         iir.id = IIR_RLS;
    else if (ier_q.erbfi && rx_trig_hit_i) iir.id = IIR_RDA;
    else if (ier_q.erbfi && rx_timeout_i)  iir.id = IIR_CTO;
    else if (ier_q.etbei && thre_pend_q)   iir.id = IIR_THRE;
`endif
  end

  // Read value reflects state before any same-cycle write.
  always_comb begin
    rd_data_o = 8'h00;
    case (addr_i)
      UART_OFS_RBR: rd_data_o = lcr_q.dlab ? div_q.dll : rx_data_i;
      UART_OFS_IER: rd_data_o = lcr_q.dlab ? div_q.dlm : ier_q;
      UART_OFS_IIR: rd_data_o = iir;
      UART_OFS_LCR: rd_data_o = lcr_q;
      UART_OFS_LSR: rd_data_o = lsr;
      UART_OFS_SCR: rd_data_o = scr_q;
      default:      rd_data_o = 8'h00;
    endcase
  end

  always_comb begin
    lcr_d       = lcr_q;
    div_d       = div_q;
    fcr_d       = fcr_q;
    ier_d       = ier_q;
    scr_d       = scr_q;
    sticky_d    = sticky_q;
    thre_pend_d = thre_pend_q;
    rx_pop_d    = 1'b0;
    tx_push_d   = 1'b0;
    rx_rst_d    = 1'b0;
    tx_rst_d    = 1'b0;
    irq_d       = 1'b0;

    if (rd_i && addr_i == UART_OFS_LSR) sticky_d = '0;
    if (rd_i && addr_i == UART_OFS_RBR && !lcr_q.dlab) rx_pop_d = 1'b1;
    if (rd_i && addr_i == UART_OFS_IIR && iir.id == IIR_THRE) thre_pend_d = 1'b0;

    if (wr_i) begin
      case (addr_i)
        UART_OFS_RBR: begin
          if (lcr_q.dlab) div_d.dll = wdata_i;
          else begin
            tx_push_d   = 1'b1;
            thre_pend_d = 1'b0;
          end
        end
        UART_OFS_IER: begin
          if (lcr_q.dlab) div_d.dlm = wdata_i;
`ifdef UART_CSR_IRQ_EN
          else            ier_d     = {4'b0000, wdata_i[3:0]};
`endif
        end
        UART_OFS_IIR: begin
          fcr_d    = fcr_store(wdata_i);
          rx_rst_d = wdata_i[1];
          tx_rst_d = wdata_i[2];
        end
        UART_OFS_LCR: lcr_d = wdata_i;
        UART_OFS_SCR: scr_d = wdata_i;
        default: ;
      endcase
    end

    // An event arriving with the clearing read must not be lost.
    sticky_d = sticky_d | {bi_i, fe_i, pe_i, oe_i};

`ifdef UART_CSR_IRQ_EN
    if ((thre_i && !thre_pend_src_q()) ||
        (wr_i && addr_i == UART_OFS_IER && !lcr_q.dlab && wdata_i[1] && !ier_q.etbei && thre_i))
      thre_pend_d = 1'b1;
    irq_d = ~iir.id[0];
`else
    thre_pend_d = 1'b0;
`endif
  end

`ifdef UART_CSR_IRQ_EN
  logic thre_q;
  function automatic logic thre_pend_src_q();
    return thre_q;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thre_q <= 1'b0;
    else     thre_q <= thre_i;
  end
`else
  logic unused_irq_sources;
  assign unused_irq_sources = ^{rx_trig_hit_i, rx_timeout_i, thre_pend_q, irq_d};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcr_q       <= LCR_RESET;
      div_q       <= DIV_RESET;
      fcr_q       <= '0;
      ier_q       <= '0;
      scr_q       <= '0;
      sticky_q    <= '0;
      thre_pend_q <= 1'b0;
      rx_pop_q    <= 1'b0;
      tx_push_q   <= 1'b0;
      rx_rst_q    <= 1'b0;
      tx_rst_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      lcr_q       <= lcr_d;
      div_q       <= div_d;
      fcr_q       <= fcr_d;
      ier_q       <= ier_d;
      scr_q       <= scr_d;
      sticky_q    <= sticky_d;
      thre_pend_q <= thre_pend_d;
      rx_pop_q    <= rx_pop_d;
      tx_push_q   <= tx_push_d;
      rx_rst_q    <= rx_rst_d;
      tx_rst_q    <= tx_rst_d;
      irq_q       <= irq_d;
    end
  end

  assign lcr_o      = lcr_q;
  assign div_o      = div_q;
  assign fcr_o      = fcr_q;
  assign rx_pop_o   = rx_pop_q;
  assign tx_push_o  = tx_push_q;
  assign rx_rst_p_o = rx_rst_q;
  assign tx_rst_p_o = tx_rst_q;
`ifdef UART_CSR_IRQ_EN
  assign irq_o      = irq_q;
`else
  assign irq_o      = 1'b0;
  logic unused_irq_q;
  assign unused_irq_q = irq_q;
`endif

endmodule

// File: rtl/uart_csr_bank.sv
// ----------------------------------------------------------------------------
// uart_csr_bank
//   16550-style register bank for NUM_CH UART channels on one byte-wide CSR
//   bus. Decodes the channel select, registers the read data and packs the
//   per-channel outputs. Optional feature macro: UART_CSR_IRQ_EN.
// Ports
//   clk, rst            clock, async active-high reset
//   wr_en, rd_en        one-cycle access strobes
//   ch_sel, addr, wdata channel, register offset, write data
//   rdata, rvalid       read data, valid one cycle after rd_en (data held)
//   rx_data, rx_pop     RX FIFO head bytes / pop pulses
//   tx_data, tx_push    THR data / push pulses
//   lcr_o, div_o, fcr_o packed per-channel configuration
//   rx_rst_p, tx_rst_p  FIFO reset pulses
//   rx_nonempty .. bi   LSR sources
//   rx_trig_hit, rx_timeout  RX interrupt sources
//   irq                 per-channel interrupt request
// ----------------------------------------------------------------------------
module uart_csr_bank
  import uart_csr_bank_pkg::*;
#(
  parameter  int          NUM_CH    = 2,
  parameter  logic [15:0] DIV_RESET = 16'd54,
  localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [2:0]           addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 rvalid,
  input  logic [NUM_CH*8-1:0]  rx_data,
  output logic [NUM_CH-1:0]    rx_pop,
  output logic [7:0]           tx_data,
  output logic [NUM_CH-1:0]    tx_push,
  output logic [NUM_CH*8-1:0]  lcr_o,
  output logic [NUM_CH*16-1:0] div_o,
  output logic [NUM_CH*8-1:0]  fcr_o,
  output logic [NUM_CH-1:0]    rx_rst_p,
  output logic [NUM_CH-1:0]    tx_rst_p,
  input  logic [NUM_CH-1:0]    rx_nonempty,
  input  logic [NUM_CH-1:0]    rx_fifo_err,
  input  logic [NUM_CH-1:0]    thre,
  input  logic [NUM_CH-1:0]    temt,
  input  logic [NUM_CH-1:0]    oe,
  input  logic [NUM_CH-1:0]    pe,
  input  logic [NUM_CH-1:0]    fe,
  input  logic [NUM_CH-1:0]    bi,
  input  logic [NUM_CH-1:0]    rx_trig_hit,
  input  logic [NUM_CH-1:0]    rx_timeout,
  output logic [NUM_CH-1:0]    irq
);

  logic [7:0]        chan_rd [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvalid_q;
  logic [7:0]        tx_data_q;

  // A select beyond NUM_CH hits no channel: writes vanish, reads see 0x00.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign hit[gi] = (ch_sel == CH_W'(gi));

      uart_csr_chan #(.DIV_RESET(DIV_RESET)) u_chan (
        .clk           (clk),
        .rst           (rst),
        .wr_i          (wr_en & hit[gi]),
        .rd_i          (rd_en & hit[gi]),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rx_data_i     (rx_data[gi*8 +: 8]),
        .rx_nonempty_i (rx_nonempty[gi]),
        .rx_fifo_err_i (rx_fifo_err[gi]),
        .thre_i        (thre[gi]),
        .temt_i        (temt[gi]),
        .oe_i          (oe[gi]),
        .pe_i          (pe[gi]),
        .fe_i          (fe[gi]),
        .bi_i          (bi[gi]),
        .rx_trig_hit_i (rx_trig_hit[gi]),
        .rx_timeout_i  (rx_timeout[gi]),
        .rd_data_o     (chan_rd[gi]),
        .rx_pop_o      (rx_pop[gi]),
        .tx_push_o     (tx_push[gi]),
        .lcr_o         (lcr_o[gi*8 +: 8]),
        .div_o         (div_o[gi*16 +: 16]),
        .fcr_o         (fcr_o[gi*8 +: 8]),
        .rx_rst_p_o    (rx_rst_p[gi]),
        .tx_rst_p_o    (tx_rst_p[gi]),
        .irq_o         (irq[gi])
      );
    end
  endgenerate

  always_comb begin
    rdata_d = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit[i]) rdata_d = rdata_d | chan_rd[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
      // Only meaningful alongside a tx_push pulse.
      if (wr_en && addr == UART_OFS_RBR) tx_data_q <= wdata;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign tx_data = tx_data_q;

endmodule
